// File: rtl/pool_pkg.sv
// Shared constants and state type for the 2x2 max-pool row-pair feeder.
package pool_pkg;

    localparam int POOL_DATA_W = 16;
    localparam int POOL_ROW_W  = 28;
    localparam int POOL_COLS   = POOL_ROW_W / 2;
    localparam int ROW_CNT_W   = 6;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/pool_row_reg.sv
// One full conv-row holding register; used for the even and odd pair slots.
module pool_row_reg #(
    parameter int W = pool_pkg::POOL_ROW_W * pool_pkg::POOL_DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     q <= '0;
        else if (ld) q <= d;
    end

endmodule

// File: rtl/pool_pair_feeder.sv
// Pairs consecutive conv rows for the 2x2 max-pool array; duplicates an unpaired last row.
// Optional column limiting is enabled with `define POOL_ACTIVE_COLS_EN.
module pool_pair_feeder
    import pool_pkg::*;
#(
    parameter int DATA_W = POOL_DATA_W,
    parameter int ROW_W  = POOL_ROW_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      row_valid,
    output logic                      row_ready,
    input  logic [ROW_W*DATA_W-1:0]   row_data,
    input  logic                      row_last,
`ifdef POOL_ACTIVE_COLS_EN
    input  logic [4:0]                active_cols,
`endif
    output logic                      pair_valid,
    input  logic                      pair_ready,
    output logic [2*ROW_W*DATA_W-1:0] fm_out,
    output logic [ROW_W/2-1:0]        max_en,
    output logic                      map_done
);

    localparam int COLS  = ROW_W / 2;
    localparam int ROW_B = ROW_W * DATA_W;

    feeder_state_t        state;
    logic                 pair_last;
    logic [ROW_CNT_W-1:0] row_cnt;
    logic                 row_xfer, pair_xfer, even_ld, odd_ld;
    logic [ROW_B-1:0]     even_q, odd_q;

    always_comb begin
        row_ready = (state != FULL) | pair_ready;
        row_xfer  = row_valid & row_ready;
        pair_xfer = pair_valid & pair_ready;
        // A row accepted outside HALF always opens a new pair; a last row also fills the odd slot.
        even_ld   = row_xfer & (state != HALF);
        odd_ld    = row_xfer & ((state == HALF) | row_last);
    end

    pool_row_reg #(.W(ROW_B)) u_even (.clk(clk), .rst(rst), .ld(even_ld), .d(row_data), .q(even_q));
    pool_row_reg #(.W(ROW_B)) u_odd  (.clk(clk), .rst(rst), .ld(odd_ld),  .d(row_data), .q(odd_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            pair_valid <= 1'b0;
            pair_last  <= 1'b0;
            map_done   <= 1'b0;
            row_cnt    <= '0;
        end else begin
            map_done <= pair_xfer & pair_last;

            if (row_xfer) begin
                pair_last <= row_last;
                if ((state == HALF) || row_last) begin
                    state      <= FULL;
                    pair_valid <= 1'b1;
                end else begin
                    state      <= HALF;
                    pair_valid <= 1'b0;
                end
            end else if (pair_xfer) begin
                state      <= EMPTY;
                pair_valid <= 1'b0;
            end

            if (map_done)      row_cnt <= row_xfer ? ROW_CNT_W'(1) : '0;
            else if (row_xfer) row_cnt <= row_cnt + ROW_CNT_W'(1);
        end
    end

`ifdef POOL_ACTIVE_COLS_EN
    logic [4:0]       cols_q;
    logic [4:0]       cols_eff;
    logic [ROW_W-1:0] pix_en;

    // Out-of-range widths fall back to the full row.
    always_comb begin
        cols_eff = active_cols;
        if ((active_cols == 5'd0) || active_cols[0] || (active_cols > 5'(ROW_W)))
            cols_eff = 5'(ROW_W);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          cols_q <= 5'(ROW_W);
        else if (even_ld) cols_q <= cols_eff;
    end

    for (genvar k = 0; k < ROW_W; k++) begin : g_pix
        assign pix_en[k] = cols_q > 5'(k);
        assign fm_out[k*DATA_W +: DATA_W]         = even_q[k*DATA_W +: DATA_W] & {DATA_W{pix_en[k]}};
        assign fm_out[ROW_B + k*DATA_W +: DATA_W] = odd_q[k*DATA_W +: DATA_W]  & {DATA_W{pix_en[k]}};
    end

    for (genvar i = 0; i < COLS; i++) begin : g_en
        assign max_en[i] = pair_valid & pix_en[2*i];
    end
`else
    assign fm_out = {odd_q, even_q};
    assign max_en = {COLS{pair_valid}};
`endif

endmodule
